// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a length-prefixed, XOR-checksummed byte stream,
// assembles little-endian 32-bit words and writes them to consecutive
// instruction memory words. The core is held in reset until a good load.
module instr_mem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0] word_idx_q, word_idx_d;
    logic [7:0]        csum_q, csum_d;
    // Only the lower three lanes need storage; lane 3 arrives with the write.
    logic [23:0]       word_q, word_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [31:0]         len_shift;
    logic [ADDR_WIDTH:0] word_idx_inc;

    assign len_shift    = {rx_data, len_q[31:8]};
    assign word_idx_inc = word_idx_q + 1'b1;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state logic: length capture, word assembly, checksum and writes.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN;
                    len_d      = '0;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    word_d     = '0;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    len_d      = len_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        word_idx_d = '0;
                        csum_d     = '0;
                        if (len_shift == 32'd0 || len_shift > MAX_WORDS) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {{(30 - ADDR_WIDTH){1'b0}},
                                           word_idx_q[ADDR_WIDTH-1:0], 2'b00};
                            mem_wdata_d = {rx_data, word_q};
                            word_idx_d  = word_idx_inc;
                            if (word_idx_inc == len_q[ADDR_WIDTH:0]) begin
                                state_d = ST_CSUM;
                            end
                        end
                    endcase
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        rx_ready  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
        busy      = rx_ready;
        done      = (state_q == ST_DONE);
        error     = (state_q == ST_ERR);
        core_hold = (state_q != ST_DONE);
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-stream program loader that fills the instruction memory before the single-cycle core starts fetching. It is the write-side counterpart of the core's instruction fetch port. It receives a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to the instruction memory write port at consecutive word addresses. The core is held in reset until a load completes with a good checksum.

## Interface
- ADDR_WIDTH, 10, word-address width of instruction memory; MAX_WORDS = 2**ADDR_WIDTH
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a load; honoured only in IDLE, DONE, ERR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid && rx_ready
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  32  byte address = {word_idx, 2'b00}, zero-extended
- mem_wdata  out  32  assembled word
- core_hold  out  1  high = keep core in reset (top level maps this onto the core's reset)
- busy  out  1  high in LEN, DATA, CSUM
- done  out  1  high in DONE
- error  out  1  high in ERR

## Operation
- Stream format: 4-byte word count N (little-endian), then 4·N payload bytes (little-endian words), then 1 checksum byte = XOR of all payload bytes. The length bytes are excluded from the checksum.
- States:
  - IDLE: reset state; rx_ready=0, core_hold=1; start → LEN.
  - LEN: rx_ready=1; shifts in 4 bytes (first byte = bits 7:0). After the 4th byte, N==0 or N>MAX_WORDS → ERR; otherwise → DATA. word_idx, byte counter and checksum are cleared on entry.
  - DATA: rx_ready=1. Each accepted byte goes into lane byte_cnt and is XORed into the checksum. On the 4th byte of a word, the full word is registered and mem_we pulses the next cycle with the current word_idx, after which word_idx increments. Acceptance of the last byte of word N-1 → CSUM.
  - CSUM: rx_ready=1; accepts 1 byte. Byte equal to checksum → DONE; otherwise → ERR.
  - DONE: core_hold=0, done=1, rx_ready=0; start → LEN (core_hold returns to 1).
  - ERR: error=1, core_hold=1, rx_ready=0; start → LEN, which clears error.
- start outside IDLE/DONE/ERR is ignored.
- rx_valid low stalls any state indefinitely with no state change.
- Memory contents are never cleared. A failed or aborted load leaves partially written words; core_hold keeps the core from running them.

## Timing
- Reset values: state IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, busy=0, done=0, error=0; internal counters and checksum 0.
- Sustained rate: one byte per cycle. rx_ready stays high through write cycles, so no bubble is inserted.
- Write latency: mem_we is asserted exactly 1 cycle after the 4th byte of a word is accepted. mem_addr and mem_wdata are valid in that same cycle and hold until the next write.
- The last word's mem_we falls in the first CSUM cycle. It completes even if the checksum byte arrives in that same cycle.
- done/core_hold change 1 cycle after the checksum byte is accepted.
- ERR from a bad length is entered 1 cycle after the 4th length byte is accepted; no writes occur.
- rst asserted mid-load: the next edge forces all reset values and any pending mem_we is dropped.
- Word address wraps are impossible because N ≤ MAX_WORDS. word_idx needs ADDR_WIDTH+1 bits to count to MAX_WORDS.

## Test plan
- Nominal load: start; N=3; words 0x00500093, 0x00A00113, 0x002081B3 sent as LE bytes; checksum = XOR of the 12 bytes → three mem_we pulses at addr 0x0, 0x4, 0x8 with those wdata, then done=1 and core_hold=0.
- Bad checksum: same stream with checksum^0x01 → all 3 writes occur, then error=1, core_hold=1, done=0. A following start restarts at LEN with error cleared.
- Bad length: N=0, and separately N=MAX_WORDS+1 → ERR one cycle after the 4th length byte, no mem_we.
- Backpressure/gaps: rx_valid toggled randomly (50%) during the nominal load → identical write sequence; no byte is lost or duplicated.
- Full memory: N=MAX_WORDS (1024) with pattern word i = i·4 → last write at addr 0xFFC, then done.
- Mid-load reset: rst for 1 cycle after 5 payload bytes → all outputs at reset values next cycle; a fresh start and full stream then loads correctly.
